multiport_regfile: RTL and testbench
====================================

# multiport_regfile

Parametrised general-purpose register file for the pipelined CPU datapath, the next generation of the single-write, two-read GRF. It has a configurable number of read and write ports, optional same-cycle write-to-read bypass and a per-register pending scoreboard for hazard detection. It also provides a registered write-trace port that replaces simulation-only printing. It sits between decode (read and scoreboard-set) and writeback (write and scoreboard-clear).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2); higher index has higher priority
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 hardwired to zero
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  combinational read data
- rd_busy  out  NUM_RD  addressed register has a pending producer
- wr_en  in  NUM_WR  write strobe per port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_pc  in  NUM_WR*32  PC of the writing instruction (trace only)
- sb_set_en  in  1  mark sb_set_addr pending (decode issues producer)
- sb_set_addr  in  ADDR_W  destination being issued
- busy_cnt  out  ADDR_W+1  number of registers currently pending
- trc_valid  out  NUM_WR  registered: port committed a write last cycle
- trc_pc / trc_addr / trc_data  out  NUM_WR*32 / NUM_WR*ADDR_W / NUM_WR*DATA_W  registered trace of that write

## Operation
- Write accepted on port p: wr_en[p]=1, and not (ZERO_REG=1 and wr_addr=0). Array updated at the rising edge.
- Two accepted writes to the same address: port NUM_WR-1 wins the array. Both ports still produce a trace entry.
- Read with ZERO_REG=1 and address 0: returns 0 and rd_busy=0.
- BYPASS=1: a read matching an accepted same-cycle write returns that wr_data (highest matching port).
- BYPASS=0: reads always return the stored value; new data is visible the cycle after the write.
- Scoreboard:
  - An accepted write clears pending[addr] at the edge.
  - sb_set_en sets pending[sb_set_addr] at the edge; it is ignored for address 0 when ZERO_REG=1.
  - Set and clear of the same address in one cycle: set wins, because a newer producer has been issued.
- rd_busy[i] = pending[rd_addr[i]]. With BYPASS=1, rd_busy[i] is forced to 0 when an accepted same-cycle write matches that address and no same-cycle set targets it.
- busy_cnt is a registered population count of the pending bits. It is updated incrementally by +set −clear per cycle, never recomputed, and must equal the popcount at all times.
- Trace: trc_* for port p are loaded at the edge on which the write is accepted. trc_valid[p]=0 in cycles without an accepted write; trc_pc/addr/data hold their last values.

## Timing
- Read: zero latency, combinational from rd_addr (and from wr_* when BYPASS=1).
- Write to stored data: 1 edge. Trace: valid in the cycle after the write.
- Scoreboard set/clear: effective from the cycle after the edge; busy_cnt is updated on the same edge.
- Reset, taking effect at the next edge, including during writes:
  - all registers = 0, all pending = 0, busy_cnt = 0, trc_valid = 0, trc_pc/addr/data = 0
  - writes and sets in the reset cycle are discarded
  - rd_data reflects the cleared array from the cycle after reset

## Structure
- Shared package rf_pkg holds:
  - default DATA_W/ADDR_W constants
  - a function that returns the winning write-port index for a given address match vector
  - the trace-record typedef (pc, addr, data)
- Sub-module rf_scoreboard holds the pending bits, the set/clear priority logic and busy_cnt. It is instantiated once; the top level holds the data array, bypass muxes and trace registers.

## Test plan
- Reset then read all 32 addresses: rd_data=0, rd_busy=0, busy_cnt=0.
- Port 0 writes r5=0x1234_5678 with pc=0x3000. With BYPASS=1, rd_addr=5 shows 0x1234_5678 in the same cycle; next cycle trc_valid=01, trc_pc=0x3000, trc_addr=5. With BYPASS=0, the value appears only the next cycle.
- Both ports write r7 in the same cycle (0xAAAA on port 0, 0xBBBB on port 1): stored r7=0xBBBB, both trace entries valid.
- Write 0xFFFF_FFFF to r0: rd_data=0, no trace, pending unaffected.
- Scoreboard:
  - sb_set r9 and r10 → busy_cnt=2.
  - Write r9 → busy_cnt=1.
  - Same-cycle sb_set r10 and write r10 → r10 stays busy, busy_cnt=1.
- Assert reset during a cycle with write r3 and sb_set r4: next cycle r3=0, r4 not busy, busy_cnt=0, trc_valid=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, write-port arbitration and trace record for the register file
package rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_WR     = 2;

  typedef struct packed {
    logic [31:0]           pc;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } trc_rec_t;

  // Highest-numbered matching port wins; 0 when nothing matches.
  function automatic int win_port(input logic [MAX_WR-1:0] match);
    int w;
    w = 0;
    for (int p = 0; p < MAX_WR; p++)
      if (match[p]) w = p;
    return w;
  endfunction
endpackage

// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - read, write, scoreboard and trace bundle of the register file
interface multiport_regfile_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR*32-1:0]     wr_pc;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic [NUM_WR-1:0]        trc_valid;
  logic [NUM_WR*32-1:0]     trc_pc;
  logic [NUM_WR*ADDR_W-1:0] trc_addr;
  logic [NUM_WR*DATA_W-1:0] trc_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, busy_cnt, trc_valid, trc_pc, trc_addr, trc_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_cnt, trc_valid, trc_pc, trc_addr, trc_data
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set-over-clear priority and a running busy count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic [NUM_WR-1:0]        clr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] clr_addr_i,
  output logic [2**ADDR_W-1:0]     pending_o,
  output logic [ADDR_W:0]          busy_cnt_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              set_eff;
  logic              dup;
  logic [ADDR_W-1:0] ca;

  assign set_eff = set_en_i && !(ZERO_REG && set_addr_i == '0);

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    dup       = 1'b0;
    ca        = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (clr_en_i[p]) pending_d[clr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
    if (set_eff) pending_d[set_addr_i] = 1'b1;
    if (set_eff && !pending_q[set_addr_i]) cnt_d = cnt_d + ONE;
    // A register retired by both ports in one cycle leaves the count once.
    for (int p = 0; p < NUM_WR; p++) begin
      ca  = clr_addr_i[p*ADDR_W +: ADDR_W];
      dup = 1'b0;
      for (int q = 0; q < p; q++)
        if (clr_en_i[q] && clr_addr_i[q*ADDR_W +: ADDR_W] == ca) dup = 1'b1;
      if (clr_en_i[p] && !dup && pending_q[ca] && !(set_eff && set_addr_i == ca))
        cnt_d = cnt_d - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o  = pending_q;
  assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multi-port GRF with optional write bypass, hazard scoreboard and write trace
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                clk,
  input logic                reset,
  multiport_regfile_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_WR-1:0]        wr_acc;
  logic [DEPTH-1:0]         pending;
  logic [NUM_WR-1:0]        trc_valid_q;
  logic [NUM_WR*32-1:0]     trc_pc_q;
  logic [NUM_WR*ADDR_W-1:0] trc_addr_q;
  logic [NUM_WR*DATA_W-1:0] trc_data_q;
  logic [ADDR_W-1:0]        ra;
  logic [MAX_WR-1:0]        match;
  logic                     hit, set_hit, busy;
  logic [DATA_W-1:0]        data;

  always_comb begin
    wr_acc = '0;
    for (int p = 0; p < NUM_WR; p++)
      wr_acc[p] = bus.wr_en[p] && !(ZERO_REG && bus.wr_addr[p*ADDR_W +: ADDR_W] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_acc[p]) mem_q[bus.wr_addr[p*ADDR_W +: ADDR_W]] <= bus.wr_data[p*DATA_W +: DATA_W];
    end
  end

  // A forwarded write hides the pending bit unless a newer producer is issued the same cycle.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra      = '0;
    match   = '0;
    hit     = 1'b0;
    set_hit = 1'b0;
    busy    = 1'b0;
    data    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      match = '0;
      for (int p = 0; p < NUM_WR; p++)
        match[p] = wr_acc[p] && bus.wr_addr[p*ADDR_W +: ADDR_W] == ra;
      hit     = BYPASS && (|match);
      set_hit = bus.sb_set_en && bus.sb_set_addr == ra;
      data    = hit ? bus.wr_data[win_port(match)*DATA_W +: DATA_W] : mem_q[ra];
      busy    = pending[ra] && !(hit && !set_hit);
      if (ZERO_REG && ra == '0) begin
        data = '0;
        busy = 1'b0;
      end
      bus.rd_data[i*DATA_W +: DATA_W] = data;
      bus.rd_busy[i] = busy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trc_valid_q <= '0;
      trc_pc_q    <= '0;
      trc_addr_q  <= '0;
      trc_data_q  <= '0;
    end else begin
      trc_valid_q <= wr_acc;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_acc[p]) begin
          trc_pc_q[p*32 +: 32]         <= bus.wr_pc[p*32 +: 32];
          trc_addr_q[p*ADDR_W +: ADDR_W] <= bus.wr_addr[p*ADDR_W +: ADDR_W];
          trc_data_q[p*DATA_W +: DATA_W] <= bus.wr_data[p*DATA_W +: DATA_W];
        end
    end
  end

  assign bus.trc_valid = trc_valid_q;
  assign bus.trc_pc    = trc_pc_q;
  assign bus.trc_addr  = trc_addr_q;
  assign bus.trc_data  = trc_data_q;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (bus.sb_set_en),
    .set_addr_i (bus.sb_set_addr),
    .clr_en_i   (wr_acc),
    .clr_addr_i (bus.wr_addr),
    .pending_o  (pending),
    .busy_cnt_o (bus.busy_cnt)
  );
endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - self-checking bench for multiport_regfile, bypass and non-bypass builds
module tb_multiport_regfile;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();
  multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_nb ();

  assign bus_nb.rd_addr     = bus.rd_addr;
  assign bus_nb.wr_en       = bus.wr_en;
  assign bus_nb.wr_addr     = bus.wr_addr;
  assign bus_nb.wr_data     = bus.wr_data;
  assign bus_nb.wr_pc       = bus.wr_pc;
  assign bus_nb.sb_set_en   = bus.sb_set_en;
  assign bus_nb.sb_set_addr = bus.sb_set_addr;

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1), .ZERO_REG(1'b1))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0), .ZERO_REG(1'b1))
    u_dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  // Reference state: architectural registers, pending flags, last trace per port.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  logic [NW-1:0] m_tv;
  trc_rec_t      m_trc [NW];

  function automatic logic [AW-1:0] w_addr(int p);
    return bus.wr_addr[p*AW +: AW];
  endfunction

  function automatic bit w_acc(int p);
    return bus.wr_en[p] === 1'b1 && w_addr(p) != '0;
  endfunction

  function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a, bit byp);
    logic [DW-1:0] r;
    if (a == '0) return '0;
    r = m_mem[a];
    if (byp)
      for (int p = 0; p < NW; p++)
        if (w_acc(p) && w_addr(p) == a) r = bus.wr_data[p*DW +: DW];
    return r;
  endfunction

  function automatic bit exp_busy(logic [AW-1:0] a, bit byp);
    bit fwd;
    fwd = 1'b0;
    if (a == '0) return 1'b0;
    for (int p = 0; p < NW; p++)
      if (w_acc(p) && w_addr(p) == a) fwd = 1'b1;
    if (byp && fwd && !(bus.sb_set_en && bus.sb_set_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int r = 0; r < DEPTH; r++) if (m_pend[r]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r]  = '0;
        m_pend[r] = 1'b0;
      end
      m_tv = '0;
      for (int p = 0; p < NW; p++) m_trc[p] = '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        m_tv[p] = w_acc(p);
        if (w_acc(p)) begin
          m_mem[w_addr(p)]  = bus.wr_data[p*DW +: DW];
          m_pend[w_addr(p)] = 1'b0;
          m_trc[p] = '{pc: bus.wr_pc[p*32 +: 32], addr: w_addr(p), data: bus.wr_data[p*DW +: DW]};
        end
      end
      if (bus.sb_set_en && bus.sb_set_addr != '0) m_pend[bus.sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_pc       = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
  endtask

  task automatic wr(int p, logic [AW-1:0] a, logic [DW-1:0] d, logic [31:0] pc);
    bus.wr_en[p]            = 1'b1;
    bus.wr_addr[p*AW +: AW] = a;
    bus.wr_data[p*DW +: DW] = d;
    bus.wr_pc[p*32 +: 32]   = pc;
  endtask

  task automatic sb_set(logic [AW-1:0] a);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = a;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = {AW'(DEPTH-1-a), AW'(a)};
      @(negedge clk);
      checks++;
      if (bus.rd_data !== '0 || bus.rd_busy !== '0) begin
        failures++;
        $display("FAIL reset_read addr=%0d data=%h busy=%b expected 0/0", a, bus.rd_data, bus.rd_busy);
      end
      checks++;
      if (bus.busy_cnt !== '0 || bus.trc_valid !== '0) begin
        failures++;
        $display("FAIL reset_state busy_cnt=%0d trc_valid=%b expected 0/0", bus.busy_cnt, bus.trc_valid);
      end
      tick();
    end
  endtask

  task automatic test_write_bypass();
    idle();
    bus.rd_addr = {AW'(0), AW'(5)};
    wr(0, 5, 32'h1234_5678, 32'h3000);
    @(negedge clk);
    checks++;
    if (bus.rd_data[DW-1:0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h expected=12345678", bus.rd_data[DW-1:0]);
    end
    checks++;
    if (bus_nb.rd_data[DW-1:0] !== exp_data(5, 1'b0)) begin
      failures++;
      $display("FAIL nobypass_same_cycle got=%h expected=%h", bus_nb.rd_data[DW-1:0], exp_data(5, 1'b0));
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.trc_valid !== 2'b01 || bus.trc_pc[31:0] !== 32'h3000 || bus.trc_addr[AW-1:0] !== 5'd5) begin
      failures++;
      $display("FAIL trace_after_write valid=%b pc=%h addr=%0d expected 01/3000/5",
               bus.trc_valid, bus.trc_pc[31:0], bus.trc_addr[AW-1:0]);
    end
    checks++;
    if (bus_nb.rd_data[DW-1:0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL nobypass_next_cycle got=%h expected=12345678", bus_nb.rd_data[DW-1:0]);
    end
    tick();
  endtask

  task automatic test_same_addr();
    idle();
    bus.rd_addr = {AW'(0), AW'(7)};
    wr(0, 7, 32'h0000_AAAA, 32'h4000);
    wr(1, 7, 32'h0000_BBBB, 32'h4004);
    @(negedge clk);
    checks++;
    if (bus.rd_data[DW-1:0] !== 32'h0000_BBBB) begin
      failures++;
      $display("FAIL same_addr_bypass got=%h expected=0000bbbb", bus.rd_data[DW-1:0]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rd_data[DW-1:0] !== 32'h0000_BBBB || bus_nb.rd_data[DW-1:0] !== 32'h0000_BBBB) begin
      failures++;
      $display("FAIL same_addr_stored got=%h/%h expected=0000bbbb", bus.rd_data[DW-1:0], bus_nb.rd_data[DW-1:0]);
    end
    checks++;
    if (bus.trc_valid !== 2'b11 || bus.trc_data !== {32'h0000_BBBB, 32'h0000_AAAA}) begin
      failures++;
      $display("FAIL same_addr_trace valid=%b data=%h expected 11/0000bbbb0000aaaa", bus.trc_valid, bus.trc_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    int cnt0;
    idle();
    cnt0 = exp_cnt();
    bus.rd_addr = {AW'(0), AW'(0)};
    wr(0, 0, 32'hFFFF_FFFF, 32'h5000);
    @(negedge clk);
    checks++;
    if (bus.rd_data !== '0 || bus_nb.rd_data !== '0 || bus.rd_busy !== '0) begin
      failures++;
      $display("FAIL zero_reg_read data=%h/%h busy=%b expected 0", bus.rd_data, bus_nb.rd_data, bus.rd_busy);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.trc_valid !== '0 || bus.busy_cnt !== (AW+1)'(cnt0) || bus.rd_data !== '0) begin
      failures++;
      $display("FAIL zero_reg_after valid=%b busy_cnt=%0d data=%h expected 0/%0d/0",
               bus.trc_valid, bus.busy_cnt, bus.rd_data, cnt0);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set(9);
    tick();
    idle();
    sb_set(10);
    tick();
    idle();
    bus.rd_addr = {AW'(10), AW'(9)};
    @(negedge clk);
    checks++;
    if (bus.busy_cnt !== 6'd2 || bus.rd_busy !== 2'b11) begin
      failures++;
      $display("FAIL sb_two_set busy_cnt=%0d busy=%b expected 2/11", bus.busy_cnt, bus.rd_busy);
    end
    tick();
    wr(0, 9, 32'h0000_0099, 32'h6000);
    @(negedge clk);
    checks++;
    if (bus.rd_busy !== 2'b10 || bus_nb.rd_busy !== 2'b11) begin
      failures++;
      $display("FAIL sb_write_fwd busy=%b nb_busy=%b expected 10/11", bus.rd_busy, bus_nb.rd_busy);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.busy_cnt !== 6'd1 || bus.rd_busy !== 2'b10) begin
      failures++;
      $display("FAIL sb_clear busy_cnt=%0d busy=%b expected 1/10", bus.busy_cnt, bus.rd_busy);
    end
    sb_set(10);
    wr(1, 10, 32'h0000_0010, 32'h6004);
    @(negedge clk);
    checks++;
    if (bus.rd_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_clear_same_fwd busy=%b expected 1", bus.rd_busy[1]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.busy_cnt !== 6'd1 || bus.rd_busy !== 2'b10) begin
      failures++;
      $display("FAIL sb_set_wins busy_cnt=%0d busy=%b expected 1/10", bus.busy_cnt, bus.rd_busy);
    end
    tick();
  endtask

  task automatic test_reset_during_write();
    idle();
    wr(0, 3, 32'h0000_CAFE, 32'h7000);
    tick();
    idle();
    wr(0, 3, 32'h0000_5555, 32'h7004);
    sb_set(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.rd_addr = {AW'(4), AW'(3)};
    @(negedge clk);
    checks++;
    if (bus.rd_data !== '0 || bus_nb.rd_data !== '0 || bus.rd_busy !== '0) begin
      failures++;
      $display("FAIL reset_mid_write data=%h/%h busy=%b expected 0", bus.rd_data, bus_nb.rd_data, bus.rd_busy);
    end
    checks++;
    if (bus.busy_cnt !== '0 || bus.trc_valid !== '0 || bus.trc_pc !== '0) begin
      failures++;
      $display("FAIL reset_mid_state busy_cnt=%0d valid=%b pc=%h expected 0", bus.busy_cnt, bus.trc_valid, bus.trc_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] ra;
    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) == 1) wr(p, AW'($urandom_range(0, 7)), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) sb_set(AW'($urandom_range(0, 7)));
      bus.rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        ra = bus.rd_addr[i*AW +: AW];
        checks++;
        if (bus.rd_data[i*DW +: DW] !== exp_data(ra, 1'b1) || bus.rd_busy[i] !== exp_busy(ra, 1'b1)) begin
          failures++;
          $display("FAIL rand_read_bypass cyc=%0d port=%0d addr=%0d got=%h/%b expected=%h/%b", c, i, ra,
                   bus.rd_data[i*DW +: DW], bus.rd_busy[i], exp_data(ra, 1'b1), exp_busy(ra, 1'b1));
        end
        checks++;
        if (bus_nb.rd_data[i*DW +: DW] !== exp_data(ra, 1'b0) || bus_nb.rd_busy[i] !== exp_busy(ra, 1'b0)) begin
          failures++;
          $display("FAIL rand_read_nobypass cyc=%0d port=%0d addr=%0d got=%h/%b expected=%h/%b", c, i, ra,
                   bus_nb.rd_data[i*DW +: DW], bus_nb.rd_busy[i], exp_data(ra, 1'b0), exp_busy(ra, 1'b0));
        end
      end
      checks++;
      if (bus.busy_cnt !== (AW+1)'(exp_cnt()) || bus_nb.busy_cnt !== (AW+1)'(exp_cnt())) begin
        failures++;
        $display("FAIL rand_busy_cnt cyc=%0d got=%0d/%0d expected=%0d", c, bus.busy_cnt, bus_nb.busy_cnt, exp_cnt());
      end
      checks++;
      if (bus.trc_valid !== m_tv) begin
        failures++;
        $display("FAIL rand_trc_valid cyc=%0d got=%b expected=%b", c, bus.trc_valid, m_tv);
      end
      for (int p = 0; p < NW; p++) begin
        checks++;
        if ({bus.trc_pc[p*32 +: 32], bus.trc_addr[p*AW +: AW], bus.trc_data[p*DW +: DW]} !== m_trc[p]) begin
          failures++;
          $display("FAIL rand_trc_rec cyc=%0d port=%0d got=%h/%0d/%h expected=%h/%0d/%h", c, p,
                   bus.trc_pc[p*32 +: 32], bus.trc_addr[p*AW +: AW], bus.trc_data[p*DW +: DW],
                   m_trc[p].pc, m_trc[p].addr, m_trc[p].data);
        end
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    test_reset();
    test_write_bypass();
    test_same_addr();
    test_zero_reg();
    test_scoreboard();
    test_reset_during_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
